// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with programmable almost-full and almost-empty
// thresholds, an occupancy count, and either a registered or a first-word-fall-through read.
module fifo_sync_param #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 8,
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1,
  parameter int FWFT      = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH-1:0]             data_in,
  input  logic                         wr_en,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             data_out,
  output logic                         full,
  output logic                         almostfull,
  output logic                         empty,
  output logic                         almostempty,
  output logic                         overflow,
  output logic                         underflow,
  output logic                         wr_ack,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          overflow_reg, underflow_reg, wr_ack_reg;
  logic          wr_ok, rd_ok;

  // Flags decode the registered count only, so they move only on an edge or reset.
  always_comb begin
    full        = (count_reg == DEPTH_C);
    empty       = (count_reg == '0);
    almostfull  = (count_reg >= AFULL_C) && (count_reg < DEPTH_C);
    almostempty = (count_reg != '0) && (count_reg <= AEMPTY_C);
  end

  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  // Explicit wrap compare keeps non-power-of-two depths correct.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (wr_ok) wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PW'(1);
    if (rd_ok) rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PW'(1);
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
      wr_ack_reg    <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      overflow_reg  <= wr_en && !wr_ok;
      underflow_reg <= rd_en && !rd_ok;
      wr_ack_reg    <= wr_ok;
    end
  end

  // Storage carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_reg] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = empty ? '0 : mem[rd_ptr_reg];
    end else begin : g_std
      logic [WIDTH-1:0] data_out_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     data_out_reg <= '0;
        else if (rd_ok) data_out_reg <= mem[rd_ptr_reg];
      end
      assign data_out = data_out_reg;
    end
  endgenerate

  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
  assign wr_ack    = wr_ack_reg;
  assign count     = count_reg;

endmodule
